// File: rtl/hpdmc_pkg.sv
// Shared constants and FSM encoding for the HPDMC read-capture path.
package hpdmc_pkg;

  localparam int unsigned CAP_W    = 32;
  localparam int unsigned DL_DEPTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } win_state_t;

endpackage

// File: rtl/hpdmc_rdcapture_if.sv
// Read-data stream from the capture FIFO to the bus interface.
interface hpdmc_rdcapture_if;
  import hpdmc_pkg::*;

  logic [CAP_W-1:0] rd_data;
  logic             rd_valid;
  logic             rd_last;
  logic             rd_ready;

  modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
  modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface

// File: rtl/hpdmc_rdfifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always on rd_data.
module hpdmc_rdfifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign do_wr = wr_en && (!full || rd_en);
  assign do_rd = rd_en && !empty;

  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/hpdmc_rdcapture.sv
// Read-capture sequencer: CAS-delayed capture window, IDDR word packing and
// FIFO buffering towards the bus-side valid/ready stream.
module hpdmc_rdcapture
  import hpdmc_pkg::*;
#(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                rd_issue,
  input  logic [2:0]          cas_lat,
  output logic                iddr_ce,
  input  logic [15:0]         iddr_q0,
  input  logic [15:0]         iddr_q1,
  hpdmc_rdcapture_if.master   rd_bus,
  output logic                busy,
  output logic                overflow,
  output logic                collision
);

  localparam int unsigned      CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  win_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              coll_set;

  logic [2:0]          cas_eff;
  logic [DL_DEPTH-2:0] dl;
  logic [DL_DEPTH-1:0] tap;
  logic [DL_DEPTH-2:0] pend_mask;
  logic                start;

  logic              cap_vld;
  logic              cap_last;
  logic [CAP_W:0]    fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  assign cas_eff = (cas_lat == 3'd0) ? 3'd1 : cas_lat;

  // tap[k] is high k cycles after the issue; the start is taken one cycle
  // early so the registered window opens exactly cas_eff cycles after issue.
  assign tap   = {dl, rd_issue};
  assign start = tap[cas_eff - 3'd1];

  always_comb begin
    pend_mask = '0;
    for (int unsigned j = 0; j < DL_DEPTH - 1; j++) begin
      pend_mask[j] = ((j + 1) < 32'(cas_eff));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dl <= '0;
    end else begin
      dl <= tap[DL_DEPTH-2:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    coll_set  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_OPEN;
          cnt_nxt   = '0;
        end
      end
      ST_OPEN: begin
        if (cnt == CNT_LAST) begin
          if (start) begin
            cnt_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt  = cnt + 1'b1;
          coll_set = start;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign iddr_ce = (state == ST_OPEN);

  assign pop  = rd_bus.rd_valid && rd_bus.rd_ready;
  assign drop = cap_vld && fifo_full && !pop;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cap_vld   <= 1'b0;
      cap_last  <= 1'b0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      cap_vld  <= (state == ST_OPEN);
      cap_last <= (state == ST_OPEN) && (cnt == CNT_LAST);
      if (coll_set) collision <= 1'b1;
      if (drop)     overflow  <= 1'b1;
    end
  end

  hpdmc_rdfifo #(
    .WIDTH (CAP_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (cap_vld),
    .wr_data ({cap_last, iddr_q1, iddr_q0}),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_bus.rd_valid = !fifo_empty;
  assign rd_bus.rd_last  = fifo_dout[CAP_W];
  assign rd_bus.rd_data  = fifo_dout[CAP_W-1:0];

  assign busy = (|(dl & pend_mask)) || (state == ST_OPEN) || cap_vld || !fifo_empty;

endmodule

// File: tb/tb_hpdmc_rdcapture.sv
// Directed bench for hpdmc_rdcapture with a behavioural IDDR bank and stream monitor.
module tb_hpdmc_rdcapture;

  localparam int unsigned BL    = 4;
  localparam int unsigned DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        rd_issue;
  logic [2:0]  cas_lat;
  logic        iddr_ce;
  logic [15:0] iddr_q0;
  logic [15:0] iddr_q1;
  logic        busy;
  logic        overflow;
  logic        collision;

  hpdmc_rdcapture_if rd_bus ();

  hpdmc_rdcapture #(
    .BURST_LEN  (BL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rd_issue  (rd_issue),
    .cas_lat   (cas_lat),
    .iddr_ce   (iddr_ce),
    .iddr_q0   (iddr_q0),
    .iddr_q1   (iddr_q1),
    .rd_bus    (rd_bus.master),
    .busy      (busy),
    .overflow  (overflow),
    .collision (collision)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Bank model: capture pair idx presented the cycle after its CE cycle.
  int unsigned bank_idx;
  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bank_idx <= 0;
      iddr_q0  <= '0;
      iddr_q1  <= '0;
    end else if (iddr_ce) begin
      iddr_q0  <= 16'(2 * bank_idx);
      iddr_q1  <= 16'(2 * bank_idx + 1);
      bank_idx <= bank_idx + 1;
    end
  end

  int          ce_q[$];
  logic [32:0] word_q[$];
  int          wcyc_q[$];

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (iddr_ce) ce_q.push_back(cyc);
      if (rd_bus.rd_valid && rd_bus.rd_ready) begin
        word_q.push_back({rd_bus.rd_last, rd_bus.rd_data});
        wcyc_q.push_back(cyc);
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int t0    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    sys_rst_n       = 1'b0;
    rd_issue        = 1'b0;
    rd_bus.rd_ready = 1'b0;
    repeat (2) begin
      @(posedge sys_clk);
      #1;
    end
    sys_rst_n = 1'b1;
    ce_q.delete();
    word_q.delete();
    wcyc_q.delete();
    t0 = cyc;
  endtask

  task automatic issue(input int rel);
    goto(t0 + rel);
    rd_issue = 1'b1;
    goto(t0 + rel + 1);
    rd_issue = 1'b0;
  endtask

  function automatic int first_or_neg(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Words from a freshly reset bank: word i = {2i+1, 2i}, last every BL words.
  task automatic check_words(input string tag, input int n_exp);
    chk({tag, "_count"}, 64'(word_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < word_q.size(); i++) begin
      chk({tag, "_data"}, 64'(word_q[i][31:0]), 64'({16'(2 * i + 1), 16'(2 * i)}));
      chk({tag, "_last"}, 64'(word_q[i][32]), 64'((i % BL) == (BL - 1)));
    end
  endtask

  typedef struct {
    int          rel;
    logic [31:0] data;
    logic        last;
  } rd_vec_t;

  typedef struct {
    logic [2:0] cas;
    int         lat;
  } lat_vec_t;

  rd_vec_t  rd_tab[4];
  lat_vec_t lat_tab[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rd_tab[0] = '{15, 32'h0001_0000, 1'b0};
    rd_tab[1] = '{16, 32'h0003_0002, 1'b0};
    rd_tab[2] = '{17, 32'h0005_0004, 1'b0};
    rd_tab[3] = '{18, 32'h0007_0006, 1'b1};
    lat_tab[0] = '{3'd0, 1};
    lat_tab[1] = '{3'd1, 1};
    lat_tab[2] = '{3'd2, 2};
    lat_tab[3] = '{3'd3, 3};
    lat_tab[4] = '{3'd4, 4};
    lat_tab[5] = '{3'd5, 5};
    lat_tab[6] = '{3'd6, 6};
    lat_tab[7] = '{3'd7, 7};

    cas_lat         = 3'd3;
    sys_rst_n       = 1'b0;
    rd_issue        = 1'b0;
    rd_bus.rd_ready = 1'b0;
    repeat (2) @(posedge sys_clk);
    #2;
    chk("rst_ce",        64'(iddr_ce),          64'(0));
    chk("rst_valid",     64'(rd_bus.rd_valid),  64'(0));
    chk("rst_last",      64'(rd_bus.rd_last),   64'(0));
    chk("rst_data",      64'(rd_bus.rd_data),   64'(0));
    chk("rst_busy",      64'(busy),             64'(0));
    chk("rst_overflow",  64'(overflow),         64'(0));
    chk("rst_collision", 64'(collision),        64'(0));

    // Single read, CL3, issue at 10.
    do_reset();
    cas_lat = 3'd3;
    rd_bus.rd_ready = 1'b1;
    goto(t0 + 10);
    #2;
    chk("single_busy_at_issue", 64'(busy), 64'(0));
    rd_issue = 1'b1;
    goto(t0 + 11);
    rd_issue = 1'b0;
    #2;
    chk("single_busy_after_issue", 64'(busy), 64'(1));
    goto(t0 + 18);
    #2;
    chk("single_busy_last_word", 64'(busy), 64'(1));
    goto(t0 + 19);
    #2;
    chk("single_busy_fall", 64'(busy), 64'(0));
    goto(t0 + 25);
    chk("single_ce_count", 64'(ce_q.size()), 64'(4));
    chk("single_ce_first", 64'(first_or_neg(ce_q) - t0), 64'(13));
    chk("single_ce_lastcyc", 64'((ce_q.size() == 4) ? ce_q[3] - t0 : -1), 64'(16));
    chk("single_word_count", 64'(word_q.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < word_q.size()) begin
        chk("single_word_cyc",  64'(wcyc_q[i] - t0),    64'(rd_tab[i].rel));
        chk("single_word_data", 64'(word_q[i][31:0]),  64'(rd_tab[i].data));
        chk("single_word_last", 64'(word_q[i][32]),    64'(rd_tab[i].last));
      end
    end

    // Gapless back-to-back, CL2, issues at 10 and 14.
    do_reset();
    cas_lat = 3'd2;
    rd_bus.rd_ready = 1'b1;
    issue(10);
    issue(14);
    goto(t0 + 35);
    chk("b2b_ce_count", 64'(ce_q.size()), 64'(8));
    chk("b2b_ce_first", 64'(first_or_neg(ce_q) - t0), 64'(12));
    chk("b2b_ce_lastcyc", 64'((ce_q.size() == 8) ? ce_q[7] - t0 : -1), 64'(19));
    chk("b2b_collision", 64'(collision), 64'(0));
    check_words("b2b", 8);

    // Collision: second start lands mid-window.
    do_reset();
    cas_lat = 3'd3;
    rd_bus.rd_ready = 1'b1;
    issue(10);
    issue(12);
    goto(t0 + 35);
    chk("coll_flag", 64'(collision), 64'(1));
    chk("coll_ce_count", 64'(ce_q.size()), 64'(4));
    check_words("coll", 4);

    // Backpressure: 5 gapless bursts into a 16-entry FIFO with sink stalled.
    do_reset();
    cas_lat = 3'd2;
    for (int i = 0; i < 5; i++) issue(10 + 4 * i);
    goto(t0 + 50);
    #2;
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_collision", 64'(collision), 64'(0));
    chk("ovf_ce_count", 64'(ce_q.size()), 64'(20));
    chk("ovf_valid_held", 64'(rd_bus.rd_valid), 64'(1));
    rd_bus.rd_ready = 1'b1;
    goto(t0 + 90);
    #2;
    check_words("ovf_drain", 16);
    chk("ovf_busy_after_drain", 64'(busy), 64'(0));

    // Latency sweep from the table.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      cas_lat = lat_tab[v].cas;
      rd_bus.rd_ready = 1'b1;
      issue(5);
      goto(t0 + 30);
      chk($sformatf("lat%0d_ce_first", v), 64'(first_or_neg(ce_q) - t0), 64'(5 + lat_tab[v].lat));
      chk($sformatf("lat%0d_ce_count", v), 64'(ce_q.size()), 64'(BL));
      chk($sformatf("lat%0d_first_valid", v), 64'(first_or_neg(wcyc_q) - t0), 64'(5 + lat_tab[v].lat + 2));
    end

    // Reset in the third OPEN cycle with a collision already flagged.
    do_reset();
    cas_lat = 3'd3;
    issue(10);
    issue(12);
    goto(t0 + 15);
    #2;
    chk("mrst_pre_collision", 64'(collision), 64'(1));
    chk("mrst_pre_ce", 64'(iddr_ce), 64'(1));
    sys_rst_n = 1'b0;
    goto(t0 + 16);
    #2;
    chk("mrst_ce", 64'(iddr_ce), 64'(0));
    chk("mrst_valid", 64'(rd_bus.rd_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_overflow", 64'(overflow), 64'(0));
    chk("mrst_collision", 64'(collision), 64'(0));
    sys_rst_n = 1'b1;
    rd_bus.rd_ready = 1'b1;
    ce_q.delete();
    word_q.delete();
    wcyc_q.delete();
    goto(t0 + 40);
    #2;
    chk("mrst_stale_words", 64'(word_q.size()), 64'(0));
    chk("mrst_stale_ce", 64'(ce_q.size()), 64'(0));
    chk("mrst_busy_after", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
